// File: rtl/fp_add_arb.sv
// fp_add_arb: round-robin sequencer sharing one fp_add among NREQ requesters.
// Grants one request at a time, holds operands/rounding mode stable for the
// adder latency, captures the result and returns it with the requester id.
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   req_valid/req_ready         per-requester handshake (req_ready one-hot)
//   req_a/req_b/req_rm          packed per-requester operands and rounding mode
//   fpu_in1/in2/round_m/enable  drive the shared fp_add
//   fpu_out/fpu_flags           result and flags from fp_add
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_data/rsp_flags   response payload
//   busy                        sequencer not idle
module fp_add_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned LAT  = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_rm,
  output logic [W-1:0]      fpu_in1,
  output logic [W-1:0]      fpu_in2,
  output logic [2:0]        fpu_round_m,
  output logic              fpu_enable,
  input  logic [W-1:0]      fpu_out,
  input  logic [3:0]        fpu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_pend;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           win_c;
  logic [CW-1:0]  cnt;

  // Grant window: idle, or a response is being accepted this cycle.
  assign win_c = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    if (win_c) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx  = (32'(ptr) + k) % NREQ;
        cand = IDW'(idx);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) begin
      req_ready = NREQ'(1) << gnt_idx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (gnt_any) state_next = S_EXEC;
      S_EXEC: if (cnt == '0) state_next = S_RESP;
      S_RESP: if (rsp_ready) state_next = gnt_any ? S_EXEC : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Operand capture, latency count and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= IDW'(NREQ - 1);
      id_pend     <= '0;
      cnt         <= '0;
      fpu_in1     <= '0;
      fpu_in2     <= '0;
      fpu_round_m <= '0;
      fpu_enable  <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
    end else begin
      fpu_enable <= (state_next == S_EXEC);
      busy       <= (state_next != S_IDLE);

      if (gnt_any) begin
        fpu_in1     <= req_a[gnt_idx*W +: W];
        fpu_in2     <= req_b[gnt_idx*W +: W];
        fpu_round_m <= req_rm[gnt_idx*3 +: 3];
        id_pend     <= gnt_idx;
        ptr         <= gnt_idx;
        cnt         <= CW'(LAT);
      end else if ((state == S_EXEC) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end

      // Result is taken on the count alone; fp_add's done flag is not trusted.
      if ((state == S_EXEC) && (cnt == '0)) begin
        rsp_data  <= fpu_out;
        rsp_flags <= fpu_flags;
        rsp_id    <= id_pend;
        rsp_valid <= 1'b1;
      end else if ((state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_arb.sv
// Directed bench for fp_add_arb with a small table-driven stand-in for fp_add.
module tb_fp_add_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned IDW  = 2;
  localparam logic [31:0] FP_NANQ = 32'h7FC00000;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_rm;
  logic [W-1:0]      fpu_in1;
  logic [W-1:0]      fpu_in2;
  logic [2:0]        fpu_round_m;
  logic              fpu_enable;
  logic [W-1:0]      fpu_out;
  logic [3:0]        fpu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic [3:0]        rsp_flags;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  fp_add_arb #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_round_m(fpu_round_m),
    .fpu_enable(fpu_enable), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder: known sums from a table, anything else gives a marker.
  function automatic logic [35:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      64'h3F800000_3F800000: return {4'h0, 32'h40000000};
      64'h3F800000_40000000: return {4'h0, 32'h40400000};
      64'h40000000_40000000: return {4'h0, 32'h40800000};
      64'h3F000000_3F000000: return {4'h0, 32'h3F800000};
      64'h7F800000_FF800000: return {4'b0010, FP_NANQ};
      default:               return {4'h1, a ^ b};
    endcase
  endfunction

  // Two-stage enabled pipeline giving LAT=2 edges to a valid result.
  logic [35:0] s0, s1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= '0;
      s1 <= '0;
    end else if (fpu_enable) begin
      s0 <= fake_add(fpu_in1, fpu_in2);
      s1 <= s0;
    end
  end
  assign fpu_out   = s1[31:0];
  assign fpu_flags = s1[35:32];

  // Observe grants and accepted responses at the falling edge.
  int          gq[$];
  logic [37:0] rq[$];
  int          rv_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NREQ); k++)
        if (req_valid[k] && req_ready[k]) gq.push_back(k);
      if (rsp_valid && rsp_ready) rq.push_back({rsp_id, rsp_flags, rsp_data});
      if (rsp_valid) rv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_rm[i*3 +: 3]  = rm;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_rsp(input string tag, input int max);
    int n;
    n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
    chk(tag, 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    logic [31:0] exp_data [4];
    int          busy_gap;
    int          cyc;
    exp_data[0] = 32'h40000000;
    exp_data[1] = 32'h40400000;
    exp_data[2] = 32'h40800000;
    exp_data[3] = 32'h3F800000;

    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_rm = '0;
    #2;
    chk("reset_outs", {rsp_valid, busy, fpu_enable, req_ready, rsp_id, rsp_flags, rsp_data},
        64'd0);
    chk("reset_fpu_in", {fpu_in1, fpu_in2}, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1) single op 1.0 + 2.0, exact latency
    set_op(0, 32'h3F800000, 32'h40000000, 3'd0);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    chk("t1_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("t1_fpu_in", {fpu_in1, fpu_in2}, 64'h3F800000_40000000);
    chk("t1_rm_en_busy", {fpu_round_m, fpu_enable, busy}, {59'd0, 3'd0, 1'b1, 1'b1});
    tick();
    chk("t1_no_rsp_e1", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_no_rsp_e2", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_rsp_e3", {rsp_valid, rsp_id, rsp_flags, rsp_data}, {25'd0, 1'b1, 2'd0, 4'd0, 32'h40400000});
    chk("t1_en_off", 64'(fpu_enable), 64'd0);
    tick();
    chk("t1_rsp_1cyc", {rsp_valid, busy}, 64'd0);

    // 2) requesters 0 and 2 held valid: alternate 0,2,0,2
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000, 3'd0);
    set_op(2, 32'h40000000, 32'h40000000, 3'd0);
    gq.delete(); rq.delete();
    req_valid = 4'b0101; rsp_ready = 1'b1;
    cyc = 0;
    while (rq.size() < 4 && cyc < 100) begin
      tick();
      if (gq.size() >= 4) req_valid = '0;
      cyc++;
    end
    chk("t2_nrsp", 64'(rq.size()), 64'd4);
    chk("t2_ngnt", 64'(gq.size()), 64'd4);
    for (int i = 0; i < 4 && i < gq.size() && i < rq.size(); i++) begin
      chk($sformatf("t2_gnt%0d", i), 64'(gq[i]), 64'((i % 2) * 2));
      chk($sformatf("t2_rsp%0d", i), 64'(rq[i]),
          64'({2'((i % 2) * 2), 4'd0, ((i % 2) == 0) ? 32'h40000000 : 32'h40800000}));
    end

    // 3) response back-pressure, waiting requester granted on accept
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000, 3'd0);
    set_op(1, 32'h40000000, 32'h40000000, 3'd4);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_rsp("t3_rsp_timeout", 10);
    req_valid = 4'b0010;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold%0d", i), {rsp_valid, req_ready, rsp_id, rsp_data},
          {25'd0, 1'b1, 4'b0000, 2'd0, 32'h40400000});
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_grant1", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    chk("t3_b2b", {rsp_valid, busy, fpu_round_m, fpu_in1}, {28'd0, 1'b0, 1'b1, 3'd4, 32'h40000000});
    wait_rsp("t3_rsp2_timeout", 10);
    chk("t3_rsp2", {rsp_id, rsp_flags, rsp_data}, {26'd0, 2'd1, 4'd0, 32'h40800000});
    tick();

    // 4) +inf + -inf -> quiet NaN, invalid flag
    do_reset();
    set_op(0, 32'h7F800000, 32'hFF800000, 3'd0);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    wait_rsp("t4_rsp_timeout", 10);
    chk("t4_nan", {rsp_flags, rsp_data}, {28'd0, 4'b0010, FP_NANQ});
    tick();

    // 5) reset in the middle of EXEC discards the op
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000, 3'd5);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rst_outs", {rsp_valid, busy, fpu_enable, req_ready, rsp_id, rsp_flags, fpu_round_m},
        64'd0);
    chk("t5_rst_data", {fpu_in1, rsp_data}, 64'd0);
    tick();
    rst = 1'b1;
    rv_cnt = 0;
    repeat (6) tick();
    chk("t5_no_rsp", 64'(rv_cnt), 64'd0);

    // 6) all four valid: strict rotation from requester 0
    set_op(0, 32'h3F800000, 32'h3F800000, 3'd0);
    set_op(1, 32'h3F800000, 32'h40000000, 3'd0);
    set_op(2, 32'h40000000, 32'h40000000, 3'd0);
    set_op(3, 32'h3F000000, 32'h3F000000, 3'd0);
    gq.delete(); rq.delete();
    req_valid = 4'b1111;
    #1;
    chk("t5_first_gnt", 64'(req_ready), 64'h1);
    busy_gap = 0;
    cyc = 0;
    while (rq.size() < 8 && cyc < 200) begin
      tick();
      if (gq.size() >= 8) req_valid = '0;
      if (rq.size() < 8 && !busy) busy_gap++;
      cyc++;
    end
    chk("t6_nrsp", 64'(rq.size()), 64'd8);
    chk("t6_busy_gap", 64'(busy_gap), 64'd0);
    for (int i = 0; i < 8 && i < gq.size() && i < rq.size(); i++) begin
      chk($sformatf("t6_gnt%0d", i), 64'(gq[i]), 64'(i % 4));
      chk($sformatf("t6_rsp%0d", i), 64'(rq[i]), 64'({2'(i % 4), 4'd0, exp_data[i % 4]}));
    end
    tick();
    chk("t6_idle", {busy, rsp_valid, fpu_enable}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
